// File: rtl/otbn_mac_bignum_seq.sv
// otbn_mac_bignum_seq: sequences 16 MULQACC steps on the bignum MAC to form a 256x256->512 product
// Ports: clk_i/rst_i clock and async reset; start_i/abort_i control; operand_a_i/operand_b_i latched on start;
//        ispr_acc_wr_en_i stalls the sequence; mac_operation_o/mac_en_o drive the MAC; mac_result_i is the
//        MAC adder output; busy_o/done_o status; result_o is the 512-bit product.
package otbn_pkg;
  parameter int WLEN = 256;
  typedef struct packed {
    logic [WLEN-1:0] operand_a;
    logic [WLEN-1:0] operand_b;
    logic [1:0]      operand_a_qw_sel;
    logic [1:0]      operand_b_qw_sel;
    logic            wr_hw_sel_upper;
    logic [1:0]      pre_acc_shift_imm;
    logic            zero_acc;
    logic            shift_acc;
  } mac_bignum_operation_t;
endpackage

module otbn_mac_bignum_seq
  import otbn_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WLEN-1:0]       operand_a_i,
  input  logic [WLEN-1:0]       operand_b_i,
  input  logic                  ispr_acc_wr_en_i,
  output mac_bignum_operation_t mac_operation_o,
  output logic                  mac_en_o,
  input  logic [WLEN-1:0]       mac_result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*WLEN-1:0]     result_o
);
  localparam int QWLEN = WLEN / 4;
  // {a_qw_sel, b_qw_sel, shift} per step, column-by-column schoolbook order
  localparam logic [15:0][4:0] step_tbl = {
    5'b11110, 5'b11101, 5'b10111, 5'b11010, 5'b10100, 5'b01110, 5'b11001, 5'b10011,
    5'b01101, 5'b00111, 5'b10000, 5'b01010, 5'b00100, 5'b01001, 5'b00011, 5'b00000
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] step;
  logic [WLEN-1:0] op_a, op_b;
  logic [2*WLEN-1:0] result;
  logic run, so, cap;
  logic [1:0] slot;
  logic [4:0] ent;
  logic unused_hi;
  assign unused_hi = ^mac_result_i[WLEN-1:2*QWLEN];
  assign result_o = result;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (start_i ? RUN : IDLE)
             : (state == RUN)  ? (abort_i ? IDLE : (mac_en_o && step == 4'd15) ? DONE : RUN)
             : IDLE;
  always_comb begin
    run = state == RUN;
    ent = step_tbl[step];
    so = step == 4'd2 || step == 4'd9 || step == 4'd14;
    mac_en_o = run & ~ispr_acc_wr_en_i;
    busy_o = run;
    done_o = state == DONE;
    cap = mac_en_o && (so || step == 4'd15);
    slot = step == 4'd2 ? 2'd0 : step == 4'd9 ? 2'd1 : step == 4'd14 ? 2'd2 : 2'd3;
    mac_operation_o = run ? mac_bignum_operation_t'{
      operand_a: op_a, operand_b: op_b,
      operand_a_qw_sel: ent[4:3], operand_b_qw_sel: ent[2:1],
      wr_hw_sel_upper: 1'b0, pre_acc_shift_imm: {1'b0, ent[0]},
      zero_acc: step == 4'd0, shift_acc: so} : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      step <= '0;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
    end else if (state == IDLE && start_i) begin
      op_a <= operand_a_i;
      op_b <= operand_b_i;
      result <= '0;
      step <= '0;
    end else if (mac_en_o && !abort_i) begin
      step <= step + 4'd1;
      if (cap) result[int'(slot)*2*QWLEN +: 2*QWLEN] <= mac_result_i[2*QWLEN-1:0];
    end
  assert property (@(posedge clk_i) disable iff (rst_i) !(mac_en_o && ispr_acc_wr_en_i));
  assert property (@(posedge clk_i) disable iff (rst_i) mac_en_o |-> !$isunknown(mac_operation_o));
endmodule

// File: doc/otbn_mac_bignum_seq.md
Name: otbn_mac_bignum_seq

Overview:
Sequencer that computes a full 256x256 -> 512-bit unsigned product by issuing 16 quarter-word MULQACC operations to the bignum MAC, one per cycle. It latches both operands on start and drives the MAC operation struct and mac_en. It collects the shifted-out half-words from the MAC result into a 512-bit product register. It sits between the OTBN controller, or a dedicated wide-multiply request, and the MAC, and it stalls while an ACC ISPR write owns the accumulator.

Parameters:
- None. All widths derive from otbn_pkg::WLEN = 256. Internal localparam QWLEN = WLEN/4 = 64.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  begin multiply; accepted only in IDLE
- abort_i  input  1  cancel the running sequence
- operand_a_i  input  WLEN  multiplicand, sampled on accepted start
- operand_b_i  input  WLEN  multiplier, sampled on accepted start
- ispr_acc_wr_en_i  input  1  external ACC write this cycle; forces a stall
- mac_operation_o  output  mac_bignum_operation_t  operation presented to the MAC
- mac_en_o  output  1  MAC enable
- mac_result_i  input  WLEN  MAC operation_result (adder output), combinational, same cycle
- busy_o  output  1  sequence in progress
- done_o  output  1  one-cycle pulse: product valid
- result_o  output  2*WLEN  512-bit product

Behaviour:
- States: IDLE, RUN, DONE. Step counter is 4 bits, range 0..15.
- Reset state: IDLE, step=0, operand regs=0, result_o=0, busy_o=0, done_o=0, mac_en_o=0, mac_operation_o all fields 0.
- IDLE:
  - start_i=1 latches the operands, clears result_o to 0, sets step=0 and moves to RUN.
  - busy_o rises in the next cycle.
- RUN:
  - mac_en_o = ~ispr_acc_wr_en_i. The step advances only when mac_en_o=1.
  - On a stall the step and all outputs are held; the operation fields remain driven.
- Fixed step table (k = column, i = a quarter-word, b quarter-word = k-i):
  - step 0: k0 i0, shift 0, zero_acc=1
  - steps 1-2: k1 i0..1, shift 1; step 2 has SO
  - steps 3-5: k2 i0..2, shift 0
  - steps 6-9: k3 i0..3, shift 1; step 9 has SO
  - steps 10-12: k4 i1..3, shift 0
  - steps 13-14: k5 i2..3, shift 1; step 14 has SO
  - step 15: k6 i3, shift 0
- Operation fields:
  - operand_a and operand_b come from the latched operand registers.
  - zero_acc=1 only at step 0.
  - shift_acc=1 only at the SO steps.
  - wr_hw_sel_upper is always 0.
- Capture, when mac_en_o=1:
  - step 2: mac_result_i[127:0] -> result[127:0]
  - step 9: -> result[255:128]
  - step 14: -> result[383:256]
  - step 15: mac_result_i[127:0] -> result[511:384], then go to DONE.
- DONE: lasts one cycle. done_o=1, busy_o=0, mac_en_o=0, then return to IDLE. result_o holds until the next accepted start.
- Latency: start to done_o = 17 cycles plus the number of stall cycles.
- Flags: the MAC flag updates are a side effect. The sequencer does not gate them; the caller owns flag semantics.
- Boundary conditions:
  - start_i is ignored in RUN and DONE, with no re-latch.
  - abort_i in RUN goes to IDLE next cycle. No done_o; result_o holds a partial value; ACC contents are undefined.
  - abort_i has priority over a capture in the same cycle.
  - abort_i is ignored in IDLE and DONE.
  - start_i and abort_i together in IDLE: start wins.
  - Reset mid-RUN returns immediately to the reset state; mac_en_o drops asynchronously.
  - mac_en_o and ispr_acc_wr_en_i are never high together (assertion).
  - mac_operation_o fields are known whenever mac_en_o=1 (assertion).

Test Plan:
- a=0, b=arbitrary -> done_o at cycle 17, result_o=0, mac_en_o high for exactly 16 cycles.
- a=1, b=1 -> result_o=1. a=2^64, b=2^192 -> result_o=2^256, i.e. bit 256 set only.
- a=b=2^256-1 -> result_o = 2^512 - 2^257 + 1. Also 200 random pairs checked against a reference multiplier.
- Assert ispr_acc_wr_en_i for 3 cycles at step 9 -> mac_en_o low for those 3 cycles, step held, done_o at cycle 20, result still correct.
- abort_i at step 7 -> IDLE next cycle, no done_o. A new start afterwards gives the correct product.
- start_i pulsed during RUN -> ignored, original product returned. rst_i at step 5 -> all outputs 0 the same cycle.
